// File: rtl/vproc_result_arb_if.sv
// Result arbiter bus: per-source result inputs, empty-ID stream, one result port.
// slave = arbiter side, master = producers/consumer side. Flattened per-source fields.
interface vproc_result_arb_if #(
   parameter int unsigned XIF_ID_W = 3,
   parameter int unsigned SRC_CNT  = 4
);
   logic [SRC_CNT-1:0]          src_valid_i;
   logic [SRC_CNT-1:0]          src_ready_o;
   logic [SRC_CNT*XIF_ID_W-1:0] src_id_i;
   logic [SRC_CNT-1:0]          src_we_i;
   logic [SRC_CNT*5-1:0]        src_rd_i;
   logic [SRC_CNT*32-1:0]       src_data_i;
   logic [SRC_CNT-1:0]          src_exc_i;
   logic [SRC_CNT*6-1:0]        src_exccode_i;
   logic                        empty_valid_i;
   logic [XIF_ID_W-1:0]         empty_id_i;
   logic                        result_valid_o;
   logic                        result_ready_i;
   logic [XIF_ID_W-1:0]         result_id_o;
   logic [31:0]                 result_data_o;
   logic [4:0]                  result_rd_o;
   logic                        result_we_o;
   logic                        result_exc_o;
   logic [5:0]                  result_exccode_o;
   logic                        empty_dup_o;
   logic                        pending_o;

   modport slave (
      input  src_valid_i, src_id_i, src_we_i, src_rd_i,
      input  src_data_i, src_exc_i, src_exccode_i,
      input  empty_valid_i, empty_id_i, result_ready_i,
      output src_ready_o, result_valid_o, result_id_o,
      output result_data_o, result_rd_o, result_we_o,
      output result_exc_o, result_exccode_o,
      output empty_dup_o, pending_o
   );

   modport master (
      output src_valid_i, src_id_i, src_we_i, src_rd_i,
      output src_data_i, src_exc_i, src_exccode_i,
      output empty_valid_i, empty_id_i, result_ready_i,
      input  src_ready_o, result_valid_o, result_id_o,
      input  result_data_o, result_rd_o, result_we_o,
      input  result_exc_o, result_exccode_o,
      input  empty_dup_o, pending_o
   );
endinterface

// File: rtl/vproc_result_arb.sv
// XIF result arbiter: SRC_CNT FIFO-buffered producers plus an empty-ID bitmask,
// fixed-priority or round-robin. Ports: clk_i, async_rst_i, bus (slave modport).
module vproc_result_arb #(
   parameter int unsigned XIF_ID_W       = 3,
   parameter int unsigned SRC_CNT        = 4,
   parameter int unsigned BUF_DEPTH      = 2,
   parameter bit          RR_MODE        = 1'b0,
   parameter bit          DONT_CARE_ZERO = 1'b0
) (
   input  logic              clk_i,
   input  logic              async_rst_i,
   vproc_result_arb_if.slave bus
);
   localparam int unsigned ID_CNT = 1 << XIF_ID_W;
   localparam int unsigned SRC_W  = (SRC_CNT > 1) ? $clog2(SRC_CNT) : 1;
   localparam int unsigned PTR_W  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int unsigned CNT_W  = $clog2(BUF_DEPTH + 1);

   typedef struct packed {
      logic [XIF_ID_W-1:0] id;
      logic                we;
      logic [4:0]          rd;
      logic [31:0]         data;
      logic                exc;
      logic [5:0]          exccode;
   } res_t;

   res_t             mem_q  [SRC_CNT][BUF_DEPTH];
   res_t             mem_d  [SRC_CNT][BUF_DEPTH];
   logic [PTR_W-1:0] rptr_q [SRC_CNT];
   logic [PTR_W-1:0] rptr_d [SRC_CNT];
   logic [PTR_W-1:0] wptr_q [SRC_CNT];
   logic [PTR_W-1:0] wptr_d [SRC_CNT];
   logic [CNT_W-1:0] cnt_q  [SRC_CNT];
   logic [CNT_W-1:0] cnt_d  [SRC_CNT];

   logic [ID_CNT-1:0]   emask_q, emask_d;
   logic [SRC_W-1:0]    rr_q, rr_d;
   logic                dup_q, dup_d;
   logic                lock_q, lock_d;
   logic                lock_fifo_q, lock_fifo_d;
   logic [SRC_W-1:0]    lock_idx_q, lock_idx_d;
   logic [XIF_ID_W-1:0] lock_id_q, lock_id_d;

   logic [SRC_CNT-1:0]  fifo_ne;
   logic [SRC_CNT-1:0]  src_rdy;
   logic                fifo_hit;
   logic [SRC_W-1:0]    fifo_sel;
   logic                mask_hit;
   logic [XIF_ID_W-1:0] mask_sel;

   logic                g_valid;
   logic                g_fifo;
   logic                g_byp;
   logic [SRC_W-1:0]    g_idx;
   logic [XIF_ID_W-1:0] g_id;
   logic                hs;

   logic [XIF_ID_W-1:0] r_id;
   logic                r_we;
   logic                r_exc;
   logic [4:0]          r_rd;
   logic [31:0]         r_data;
   logic [5:0]          r_code;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Ready comes from the registered count only, so a full FIFO
   // refuses a push even in a cycle where it is being popped.
   always_comb begin
      fifo_ne = '0;
      src_rdy = '0;
      for (int s = 0; s < SRC_CNT; s++) begin
         fifo_ne[s] = (cnt_q[s] != '0);
         src_rdy[s] = (cnt_q[s] != CNT_W'(BUF_DEPTH));
      end
   end

   // FIFO candidate: RR searches from the pointer, wrapping once.
   always_comb begin
      int j;
      fifo_hit = 1'b0;
      fifo_sel = '0;
      j = 0;
      for (int k = 0; k < SRC_CNT; k++) begin
         j = RR_MODE ? int'(rr_q) + k : k;
         if (j >= int'(SRC_CNT)) j = j - int'(SRC_CNT);
         if (!fifo_hit && fifo_ne[SRC_W'(j)]) begin
            fifo_hit = 1'b1;
            fifo_sel = SRC_W'(j);
         end
      end
   end

   // Descending scan so the last hit is the lowest set ID.
   always_comb begin
      mask_hit = 1'b0;
      mask_sel = '0;
      for (int i = int'(ID_CNT) - 1; i >= 0; i--) begin
         if (emask_q[i]) begin
            mask_hit = 1'b1;
            mask_sel = XIF_ID_W'(i);
         end
      end
   end

   always_comb begin
      g_valid = 1'b0;
      g_fifo  = 1'b0;
      g_byp   = 1'b0;
      g_idx   = fifo_sel;
      g_id    = mask_sel;
      if (lock_q) begin
         g_valid = 1'b1;
         g_fifo  = lock_fifo_q;
         g_idx   = lock_idx_q;
         g_id    = lock_id_q;
      end else if (fifo_hit) begin
         g_valid = 1'b1;
         g_fifo  = 1'b1;
      end else if (mask_hit) begin
         g_valid = 1'b1;
      end else if (bus.empty_valid_i) begin
         g_valid = 1'b1;
         g_byp   = 1'b1;
         g_id    = bus.empty_id_i;
      end
   end

   assign hs = g_valid & bus.result_ready_i;

   always_comb begin
      res_t head;
      head   = mem_q[g_idx][rptr_q[g_idx]];
      r_id   = DONT_CARE_ZERO ? '0 : 'x;
      r_we   = 1'b0;
      r_exc  = 1'b0;
      r_rd   = DONT_CARE_ZERO ? '0 : 'x;
      r_data = DONT_CARE_ZERO ? '0 : 'x;
      r_code = DONT_CARE_ZERO ? '0 : 'x;
      if (g_valid) begin
         r_id = g_id;
         if (g_fifo) begin
            r_id   = head.id;
            r_we   = head.we;
            r_exc  = head.exc;
            r_rd   = head.rd;
            r_data = head.data;
            r_code = head.exccode;
         end
      end
   end

   always_comb begin
      logic push;
      logic pop;
      res_t inc;
      mem_d   = mem_q;
      rptr_d  = rptr_q;
      wptr_d  = wptr_q;
      cnt_d   = cnt_q;
      emask_d = emask_q;
      rr_d    = rr_q;
      push    = 1'b0;
      pop     = 1'b0;
      inc     = '0;
      for (int s = 0; s < SRC_CNT; s++) begin
         push = bus.src_valid_i[s] & src_rdy[s];
         pop  = hs & g_fifo & (g_idx == SRC_W'(s));
         inc.id      = bus.src_id_i[s*XIF_ID_W +: XIF_ID_W];
         inc.we      = bus.src_we_i[s];
         inc.rd      = bus.src_rd_i[s*5 +: 5];
         inc.data    = bus.src_data_i[s*32 +: 32];
         inc.exc     = bus.src_exc_i[s];
         inc.exccode = bus.src_exccode_i[s*6 +: 6];
         if (push) begin
            mem_d[s][wptr_q[s]] = inc;
            wptr_d[s] = ptr_inc(wptr_q[s]);
         end
         if (pop) rptr_d[s] = ptr_inc(rptr_q[s]);
         cnt_d[s] = cnt_q[s] + CNT_W'(push) - CNT_W'(pop);
      end
      // Clear before set: a new arrival on the retiring ID survives.
      if (hs & ~g_fifo & ~g_byp) emask_d[g_id] = 1'b0;
      // A bypass that is not accepted this cycle must be remembered.
      if (bus.empty_valid_i & ~(hs & g_byp))
         emask_d[bus.empty_id_i] = 1'b1;
      if (RR_MODE && hs && g_fifo)
         rr_d = (g_idx == SRC_W'(SRC_CNT - 1)) ? '0 : g_idx + 1'b1;
   end

   always_comb begin
      dup_d       = bus.empty_valid_i & emask_q[bus.empty_id_i];
      lock_d      = g_valid & ~bus.result_ready_i;
      lock_fifo_d = g_fifo;
      lock_idx_d  = g_idx;
      lock_id_d   = g_id;
   end

   always_ff @(posedge clk_i or posedge async_rst_i) begin
      if (async_rst_i) begin
         for (int s = 0; s < SRC_CNT; s++) begin
            rptr_q[s] <= '0;
            wptr_q[s] <= '0;
            cnt_q[s]  <= '0;
         end
         emask_q     <= '0;
         rr_q        <= '0;
         dup_q       <= 1'b0;
         lock_q      <= 1'b0;
         lock_fifo_q <= 1'b0;
         lock_idx_q  <= '0;
         lock_id_q   <= '0;
      end else begin
         rptr_q      <= rptr_d;
         wptr_q      <= wptr_d;
         cnt_q       <= cnt_d;
         emask_q     <= emask_d;
         rr_q        <= rr_d;
         dup_q       <= dup_d;
         lock_q      <= lock_d;
         lock_fifo_q <= lock_fifo_d;
         lock_idx_q  <= lock_idx_d;
         lock_id_q   <= lock_id_d;
      end
   end

   // Payload storage is qualified by the counters and needs no reset.
   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end

   assign bus.src_ready_o      = src_rdy;
   assign bus.result_valid_o   = g_valid;
   assign bus.result_id_o      = r_id;
   assign bus.result_we_o      = r_we;
   assign bus.result_exc_o     = r_exc;
   assign bus.result_rd_o      = r_rd;
   assign bus.result_data_o    = r_data;
   assign bus.result_exccode_o = r_code;
   assign bus.empty_dup_o      = dup_q;
   assign bus.pending_o        = (|fifo_ne) | (|emask_q);
endmodule

// File: tb/tb_vproc_result_arb.sv
// Bench for vproc_result_arb: fixed-priority and round-robin instances
// driven in lockstep and checked against a queue-based result model.
module tb_vproc_result_arb;
   localparam int W   = 3;
   localparam int N   = 4;
   localparam int D   = 2;
   localparam int IDS = 8;

   typedef struct packed {
      logic [W-1:0] id;
      logic         we;
      logic [4:0]   rd;
      logic [31:0]  data;
      logic         exc;
      logic [5:0]   code;
   } rec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [N-1:0] s_valid = '0;
   rec_t         s_rec [N];
   logic         e_valid_in = 1'b0;
   logic [W-1:0] e_id_in = '0;
   logic         r_ready = 1'b0;

   logic [N*W-1:0]  f_id;
   logic [N-1:0]    f_we;
   logic [N*5-1:0]  f_rd;
   logic [N*32-1:0] f_data;
   logic [N-1:0]    f_exc;
   logic [N*6-1:0]  f_code;

   always_comb begin
      f_id = '0; f_we = '0; f_rd = '0;
      f_data = '0; f_exc = '0; f_code = '0;
      for (int s = 0; s < N; s++) begin
         f_id[s*W +: W]    = s_rec[s].id;
         f_we[s]           = s_rec[s].we;
         f_rd[s*5 +: 5]    = s_rec[s].rd;
         f_data[s*32 +: 32] = s_rec[s].data;
         f_exc[s]          = s_rec[s].exc;
         f_code[s*6 +: 6]  = s_rec[s].code;
      end
   end

   vproc_result_arb_if #(.XIF_ID_W(W), .SRC_CNT(N)) bus_f ();
   vproc_result_arb_if #(.XIF_ID_W(W), .SRC_CNT(N)) bus_r ();

   assign bus_f.src_valid_i    = s_valid;
   assign bus_f.src_id_i       = f_id;
   assign bus_f.src_we_i       = f_we;
   assign bus_f.src_rd_i       = f_rd;
   assign bus_f.src_data_i     = f_data;
   assign bus_f.src_exc_i      = f_exc;
   assign bus_f.src_exccode_i  = f_code;
   assign bus_f.empty_valid_i  = e_valid_in;
   assign bus_f.empty_id_i     = e_id_in;
   assign bus_f.result_ready_i = r_ready;
   assign bus_r.src_valid_i    = s_valid;
   assign bus_r.src_id_i       = f_id;
   assign bus_r.src_we_i       = f_we;
   assign bus_r.src_rd_i       = f_rd;
   assign bus_r.src_data_i     = f_data;
   assign bus_r.src_exc_i      = f_exc;
   assign bus_r.src_exccode_i  = f_code;
   assign bus_r.empty_valid_i  = e_valid_in;
   assign bus_r.empty_id_i     = e_id_in;
   assign bus_r.result_ready_i = r_ready;

   vproc_result_arb #(
      .XIF_ID_W(W), .SRC_CNT(N), .BUF_DEPTH(D),
      .RR_MODE(1'b0), .DONT_CARE_ZERO(1'b0)
   ) u_fix (
      .clk_i(clk), .async_rst_i(rst), .bus(bus_f)
   );

   vproc_result_arb #(
      .XIF_ID_W(W), .SRC_CNT(N), .BUF_DEPTH(D),
      .RR_MODE(1'b1), .DONT_CARE_ZERO(1'b1)
   ) u_rr (
      .clk_i(clk), .async_rst_i(rst), .bus(bus_r)
   );

   int tests = 0;
   int fails = 0;

   // Model: d=0 fixed, d=1 round robin. Queue index d*N+s.
   rec_t mq [2*N][$];
   bit   emask [2][IDS];
   bit   held [2];
   int   held_kind [2];
   int   held_idx [2];
   rec_t held_rec [2];
   int   rrp [2];
   bit   dup_exp [2];
   // Prediction for the current cycle; kind 1=fifo 2=mask 3=bypass.
   bit   pv [2];
   int   pk [2];
   int   pi [2];
   rec_t pr [2];

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int q = 0; q < 2*N; q++) mq[q].delete();
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < IDS; i++) emask[d][i] = 1'b0;
         held[d] = 1'b0;
         rrp[d] = 0;
         dup_exp[d] = 1'b0;
      end
   endtask

   task automatic predict(input int d);
      pv[d] = 1'b0; pk[d] = 0; pi[d] = 0; pr[d] = '0;
      if (held[d]) begin
         pv[d] = 1'b1; pk[d] = held_kind[d];
         pi[d] = held_idx[d]; pr[d] = held_rec[d];
         return;
      end
      for (int k = 0; k < N; k++) begin
         int s;
         s = (d == 1) ? (rrp[d] + k) % N : k;
         if (!pv[d] && mq[d*N+s].size() > 0) begin
            pv[d] = 1'b1; pk[d] = 1; pi[d] = s; pr[d] = mq[d*N+s][0];
         end
      end
      for (int i = 0; i < IDS; i++) begin
         if (!pv[d] && emask[d][i]) begin
            pv[d] = 1'b1; pk[d] = 2; pr[d].id = W'(i);
         end
      end
      if (!pv[d] && e_valid_in) begin
         pv[d] = 1'b1; pk[d] = 3; pr[d].id = e_id_in;
      end
   endtask

   task automatic update(input int d);
      bit hs;
      bit rdy [N];
      hs = pv[d] && r_ready;
      for (int s = 0; s < N; s++) rdy[s] = mq[d*N+s].size() < D;
      dup_exp[d] = e_valid_in && emask[d][e_id_in];
      if (hs && pk[d] == 1) begin
         void'(mq[d*N+pi[d]].pop_front());
         if (d == 1) rrp[d] = (pi[d] + 1) % N;
      end
      if (hs && pk[d] == 2) emask[d][pr[d].id] = 1'b0;
      for (int s = 0; s < N; s++)
         if (s_valid[s] && rdy[s]) mq[d*N+s].push_back(s_rec[s]);
      if (e_valid_in && !(hs && pk[d] == 3)) emask[d][e_id_in] = 1'b1;
      held[d] = pv[d] && !r_ready;
      held_kind[d] = (pk[d] == 3) ? 2 : pk[d];
      held_idx[d] = pi[d];
      held_rec[d] = pr[d];
   endtask

   task automatic check_dut(input int d, input string nm,
      input logic v, input logic [W-1:0] id, input logic we,
      input logic exc, input logic [4:0] rd, input logic [31:0] data,
      input logic [5:0] code, input logic [N-1:0] rdy,
      input logic pend, input logic dup);
      logic [N-1:0] erdy;
      bit epend;
      epend = 1'b0;
      for (int s = 0; s < N; s++) begin
         erdy[s] = mq[d*N+s].size() < D;
         if (mq[d*N+s].size() > 0) epend = 1'b1;
      end
      for (int i = 0; i < IDS; i++) if (emask[d][i]) epend = 1'b1;
      chk({nm, "_valid"}, 32'(v), 32'(pv[d]));
      if (pv[d]) begin
         chk({nm, "_id"}, 32'(id), 32'(pr[d].id));
         chk({nm, "_we"}, 32'(we), 32'(pr[d].we));
         chk({nm, "_exc"}, 32'(exc), 32'(pr[d].exc));
         if (pk[d] == 1) begin
            chk({nm, "_rd"}, 32'(rd), 32'(pr[d].rd));
            chk({nm, "_data"}, data, pr[d].data);
            chk({nm, "_code"}, 32'(code), 32'(pr[d].code));
         end
      end else begin
         chk({nm, "_we_idle"}, 32'(we), 32'(0));
         chk({nm, "_exc_idle"}, 32'(exc), 32'(0));
      end
      chk({nm, "_src_ready"}, 32'(rdy), 32'(erdy));
      chk({nm, "_pending"}, 32'(pend), 32'(epend));
      chk({nm, "_dup"}, 32'(dup), 32'(dup_exp[d]));
   endtask

   task automatic at_neg();
      @(negedge clk);
      predict(0);
      predict(1);
      check_dut(0, "fix", bus_f.result_valid_o, bus_f.result_id_o,
         bus_f.result_we_o, bus_f.result_exc_o, bus_f.result_rd_o,
         bus_f.result_data_o, bus_f.result_exccode_o, bus_f.src_ready_o,
         bus_f.pending_o, bus_f.empty_dup_o);
      check_dut(1, "rr", bus_r.result_valid_o, bus_r.result_id_o,
         bus_r.result_we_o, bus_r.result_exc_o, bus_r.result_rd_o,
         bus_r.result_data_o, bus_r.result_exccode_o, bus_r.src_ready_o,
         bus_r.pending_o, bus_r.empty_dup_o);
   endtask

   task automatic adv();
      update(0);
      update(1);
      @(posedge clk);
      #1;
   endtask

   task automatic step();
      at_neg();
      adv();
   endtask

   task automatic set_src(input int s, input logic [W-1:0] id);
      s_valid[s] = 1'b1;
      s_rec[s].id = id;
      s_rec[s].we = 1'b1;
      s_rec[s].rd = 5'(id + 3'(s));
      s_rec[s].data = 32'hA000_0000 | (32'(s) << 8) | 32'(id);
      s_rec[s].exc = (id == 3'd7);
      s_rec[s].code = 6'(s * 8 + int'(id));
   endtask

   task automatic idle_inputs();
      s_valid = '0;
      e_valid_in = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      model_reset();
      #1;
      chk("rst_valid", 32'(bus_f.result_valid_o), 32'(0));
      chk("rst_ready", 32'(bus_f.src_ready_o), 32'hF);
      chk("rst_pending", 32'(bus_f.pending_o), 32'(0));
      chk("rst_rr_data", bus_r.result_data_o, 32'(0));
      chk("rst_rr_rd", 32'(bus_r.result_rd_o), 32'(0));
      at_neg();
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int s = 0; s < N; s++) s_rec[s] = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      do_reset();
      r_ready = 1'b1;
      step();

      // Fixed priority: src0 id2 and src2 id5 in one cycle.
      set_src(0, 3'd2);
      set_src(2, 3'd5);
      step();
      idle_inputs();
      at_neg();
      chk("fix_first", 32'(bus_f.result_id_o), 32'd2);
      adv();
      at_neg();
      chk("fix_second", 32'(bus_f.result_id_o), 32'd5);
      adv();
      step();

      // Round robin over two entries per source.
      do_reset();
      r_ready = 1'b1;
      for (int s = 0; s < N; s++) set_src(s, W'(s));
      step();
      for (int s = 0; s < N; s++) set_src(s, W'(s + 4));
      for (int k = 0; k < 8; k++) begin
         at_neg();
         chk("rr_order", 32'(bus_r.result_id_o), 32'(k));
         adv();
         s_valid = '0;
      end
      step();

      // Lock under backpressure, higher priority arrives mid-stall.
      r_ready = 1'b0;
      set_src(3, 3'd1);
      step();
      s_valid = '0;
      for (int c = 0; c < 3; c++) begin
         if (c == 0) set_src(0, 3'd6);
         at_neg();
         chk("lock_hold", 32'(bus_f.result_id_o), 32'd1);
         adv();
         s_valid = '0;
      end
      r_ready = 1'b1;
      at_neg();
      chk("lock_release", 32'(bus_f.result_id_o), 32'd1);
      adv();
      at_neg();
      chk("lock_next", 32'(bus_f.result_id_o), 32'd6);
      adv();
      step();

      // Empty IDs queued behind a busy source, then a duplicate.
      r_ready = 1'b0;
      set_src(1, 3'd3);
      step();
      s_valid = '0;
      e_valid_in = 1'b1; e_id_in = 3'd4;
      step();
      e_id_in = 3'd1;
      step();
      e_id_in = 3'd4;
      step();
      e_valid_in = 1'b0;
      at_neg();
      chk("empty_dup", 32'(bus_f.empty_dup_o), 32'd1);
      adv();
      r_ready = 1'b1;
      at_neg();
      chk("empty_src1", 32'(bus_f.result_id_o), 32'd3);
      adv();
      at_neg();
      chk("empty_id1", 32'(bus_f.result_id_o), 32'd1);
      chk("empty_we0", 32'(bus_f.result_we_o), 32'd0);
      adv();
      at_neg();
      chk("empty_id4", 32'(bus_f.result_id_o), 32'd4);
      adv();
      step();

      // Fill src2, one handshake, then async reset during a stall.
      r_ready = 1'b0;
      set_src(2, 3'd5);
      step();
      set_src(2, 3'd6);
      step();
      s_valid = '0;
      at_neg();
      chk("full_ready", 32'(bus_f.src_ready_o[2]), 32'd0);
      adv();
      r_ready = 1'b1;
      at_neg();
      chk("full_hs_ready", 32'(bus_f.src_ready_o[2]), 32'd0);
      adv();
      r_ready = 1'b0;
      at_neg();
      chk("refill_ready", 32'(bus_f.src_ready_o[2]), 32'd1);
      adv();
      set_src(2, 3'd7);
      step();
      s_valid = '0;
      #2;
      do_reset();

      // Randomised traffic against the model.
      for (int c = 0; c < 400; c++) begin
         s_valid = N'($urandom);
         for (int s = 0; s < N; s++) begin
            s_rec[s].id = W'($urandom);
            s_rec[s].we = 1'($urandom);
            s_rec[s].rd = 5'($urandom);
            s_rec[s].data = $urandom;
            s_rec[s].exc = 1'($urandom);
            s_rec[s].code = 6'($urandom);
         end
         r_ready = ($urandom_range(0, 3) != 0);
         e_valid_in = ($urandom_range(0, 4) == 0);
         e_id_in = W'($urandom);
         step();
      end
      idle_inputs();
      r_ready = 1'b1;
      repeat (20) step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
